instr_fetch_unit: RTL and testbench

- Front end of the LEGv8 pipeline. Produces the instruction stream that the decode-stage control logic consumes.
- Holds the fetch PC and issues in-order requests to instruction memory.
- Buffers returned words in a small FIFO, then presents instruction, PC and 11-bit opcode field (instr[31:21]) to decode over a valid/ready handshake.
- Handles branch redirects: discards stale in-flight responses and buffered instructions.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 200 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handshake and redirect.
// The master modport is the fetch unit; the slave modport is memory/decode/branch side.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [31:0]           imem_rsp_data;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [31:0]           dec_instr;
  logic [ADDR_WIDTH-1:0] dec_pc;
  logic [10:0]           dec_opcode;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_opcode,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_opcode,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// LEGv8 instruction fetch front end: credit-limited in-order fetch, instruction FIFO, redirect flush.
// Optional macro BRANCH_PREDECODE_EN: unconditional B words self-redirect fetch at response time.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instr_fetch_unit_if.master    bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0]            ST_FETCH   = 1'b0;
  localparam logic [0:0]            ST_FLUSH   = 1'b1;
  localparam logic [CW-1:0]         CNT_ZERO   = {CW{1'b0}};
  localparam logic [PW-1:0]         PTR_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0]         PTR_ONE    = PW'(1'b1);
  localparam logic [CW:0]           DEPTH_C    = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4'd4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         pcq_wr_q, pcq_wr_d;
  logic [PW-1:0]         pcq_rd_q, pcq_rd_d;
  logic [31:0]           fifo_instr_q [FIFO_DEPTH];
  logic [31:0]           fifo_instr_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_d    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pcq_q        [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pcq_d        [FIFO_DEPTH];
  logic                  imem_req_valid_q, imem_req_valid_d;
  logic                  dec_valid_q, dec_valid_d;
  logic [31:0]           dec_instr_q, dec_instr_d;
  logic [ADDR_WIDTH-1:0] dec_pc_q, dec_pc_d;

  logic                  req_fire_s;
  logic                  rsp_keep_s;
  logic                  rsp_drop_s;
  logic                  dec_pop_s;
  logic [ADDR_WIDTH-1:0] rsp_pc_s;
`ifdef BRANCH_PREDECODE_EN
  logic                  self_redir_s;
  logic [ADDR_WIDTH-1:0] self_target_s;
`endif

  // Handshake events; a response is dropped while stale words are still owed.
  always_comb begin
    req_fire_s = imem_req_valid_q & bus.imem_req_ready;
    rsp_drop_s = bus.imem_rsp_valid & (drop_cnt_q != CNT_ZERO);
    rsp_keep_s = bus.imem_rsp_valid & (drop_cnt_q == CNT_ZERO);
    dec_pop_s  = dec_valid_q & bus.dec_ready;
    rsp_pc_s   = pcq_q[pcq_rd_q];
`ifdef BRANCH_PREDECODE_EN
    self_redir_s  = rsp_keep_s & (bus.imem_rsp_data[31:26] == 6'b000101);
    self_target_s = rsp_pc_s + {{(ADDR_WIDTH-28){bus.imem_rsp_data[25]}},
                                bus.imem_rsp_data[25:0], 2'b00};
`endif
  end

  // Next-state for PC, counters, queues and the registered outputs.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    state_d       = state_q;
    outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(bus.imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    occ_d         = occ_q + CW'(rsp_keep_s) - CW'(dec_pop_s);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pcq_wr_d      = pcq_wr_q;
    pcq_rd_d      = pcq_rd_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    pcq_d         = pcq_q;

    if (req_fire_s) begin
      fetch_pc_d      = fetch_pc_q + PC_STEP;
      pcq_d[pcq_wr_q] = fetch_pc_q;
      pcq_wr_d        = pcq_wr_q + PTR_ONE;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    if (rsp_drop_s) begin
      drop_cnt_d = drop_cnt_q - CW'(1'b1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    if (rsp_keep_s) begin
      fifo_instr_d[wr_ptr_q] = bus.imem_rsp_data;
      fifo_pc_d[wr_ptr_q]    = rsp_pc_s;
      wr_ptr_d               = wr_ptr_q + PTR_ONE;
      pcq_rd_d               = pcq_rd_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (dec_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Every request still in flight after this edge becomes a word to discard.
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ALIGN_MASK;
      occ_d      = CNT_ZERO;
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
      pcq_wr_d   = PTR_ZERO;
      pcq_rd_d   = PTR_ZERO;
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != CNT_ZERO) ? ST_FLUSH : ST_FETCH;
    end
`ifdef BRANCH_PREDECODE_EN
    else if (self_redir_s) begin
      fetch_pc_d = self_target_s;
      pcq_wr_d   = PTR_ZERO;
      pcq_rd_d   = PTR_ZERO;
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != CNT_ZERO) ? ST_FLUSH : ST_FETCH;
    end
`endif
    else if ((state_q == ST_FLUSH) && (drop_cnt_d == CNT_ZERO)) begin
      state_d = ST_FETCH;
    end else begin
      state_d = state_q;
    end

    // Credit check uses next-cycle counts so the registered valid matches the current state.
    imem_req_valid_d = (state_d == ST_FETCH) &&
                       (({1'b0, occ_d} + {1'b0, outstanding_d}) < DEPTH_C);
    dec_valid_d      = (occ_d != CNT_ZERO);
    if (dec_valid_d) begin
      dec_instr_d = fifo_instr_d[rd_ptr_d];
      dec_pc_d    = fifo_pc_d[rd_ptr_d];
    end else begin
      dec_instr_d = 32'h0000_0000;
      dec_pc_d    = {ADDR_WIDTH{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q       <= RESET_PC;
      state_q          <= ST_FETCH;
      outstanding_q    <= CNT_ZERO;
      drop_cnt_q       <= CNT_ZERO;
      occ_q            <= CNT_ZERO;
      wr_ptr_q         <= PTR_ZERO;
      rd_ptr_q         <= PTR_ZERO;
      pcq_wr_q         <= PTR_ZERO;
      pcq_rd_q         <= PTR_ZERO;
      imem_req_valid_q <= 1'b0;
      dec_valid_q      <= 1'b0;
      dec_instr_q      <= 32'h0000_0000;
      dec_pc_q         <= {ADDR_WIDTH{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]    <= {ADDR_WIDTH{1'b0}};
        pcq_q[i]        <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      state_q          <= state_d;
      outstanding_q    <= outstanding_d;
      drop_cnt_q       <= drop_cnt_d;
      occ_q            <= occ_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      pcq_wr_q         <= pcq_wr_d;
      pcq_rd_q         <= pcq_rd_d;
      imem_req_valid_q <= imem_req_valid_d;
      dec_valid_q      <= dec_valid_d;
      dec_instr_q      <= dec_instr_d;
      dec_pc_q         <= dec_pc_d;
      fifo_instr_q     <= fifo_instr_d;
      fifo_pc_q        <= fifo_pc_d;
      pcq_q            <= pcq_d;
    end
  end

  assign bus.imem_req_valid = imem_req_valid_q;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.dec_valid      = dec_valid_q;
  assign bus.dec_instr      = dec_instr_q;
  assign bus.dec_pc         = dec_pc_q;
  assign bus.dec_opcode     = dec_instr_q[31:21];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-programmable memory model, in-order scoreboard of
// architecturally expected decode words, a per-cycle vector table and redirect sequences.
module tb_instr_fetch_unit;

  localparam int          AW  = 64;
  localparam logic [63:0] RPC = 64'h100;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        dec_rdy;
    logic        req_rdy;
    logic        exp_rv;
    logic [63:0] exp_addr;
    logic        exp_dv;
    logic [63:0] exp_pc;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;

  exp_t        exp_q[$];
  pend_t       mem_q[$];
  logic [63:0] acc_log[$];
  logic [63:0] pop_log[$];
  vec_t        vt[7];
  int          n_cmp;
  int          n_fail;
  int          cyc;
  int          mem_lat;
  logic        suppress;
  logic [63:0] sup_target;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

  instr_fetch_unit #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [31:0] mem_word(input logic [20:0] a);
    if (a == 21'h000200) return 32'h1400_0004;
    return {3'b110, a[9:2], a};
  endfunction

  function automatic int count_pc(input logic [63:0] pc);
    int n = 0;
    foreach (pop_log[k]) if (pop_log[k] == pc) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bookkeeping at the sampling point, then advance to the next cycle and drive memory.
  task automatic finish_cycle();
    if (bus.dec_valid && bus.dec_ready) begin
      pop_log.push_back(bus.dec_pc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h, expected no instruction", bus.dec_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", bus.dec_pc, e.addr);
        check("sb_instr", 64'(bus.dec_instr), 64'(e.word));
        check("sb_opcode", 64'(bus.dec_opcode), 64'(e.word[31:21]));
      end
    end
    if (bus.redirect_valid) begin
      exp_q.delete();
      suppress   = 1'b1;
      sup_target = bus.redirect_pc & ~64'h3;
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      logic [63:0] a;
      logic [31:0] w;
      a = bus.imem_req_addr;
      w = mem_word(a[20:0]);
      acc_log.push_back(a);
      mem_q.push_back('{a, cyc + mem_lat});
      if (suppress && (a == sup_target)) suppress = 1'b0;
      if (!suppress) begin
        exp_q.push_back('{a, w});
`ifdef BRANCH_PREDECODE_EN
        if (w[31:26] == 6'b000101) begin
          suppress   = 1'b1;
          sup_target = a + {{36{w[25]}}, w[25:0], 2'b00};
        end
`endif
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
      pend_t p;
      p = mem_q.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(p.addr[20:0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0000_0000;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic do_reset();
    reset_n            = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0000_0000;
    bus.dec_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    exp_q.delete();
    mem_q.delete();
    acc_log.delete();
    pop_log.delete();
    suppress = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_req_addr", bus.imem_req_addr, RPC);
    check("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
    check("rst_dec_instr", 64'(bus.dec_instr), 64'd0);
    check("rst_dec_pc", bus.dec_pc, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  initial begin
    logic [63:0] nxt;
    int          idx;
    n_cmp   = 0;
    n_fail  = 0;
    mem_lat = 1;

    // Cycle-by-cycle: accept 0x100 in c0, decode valid in c2; credit stalls in c2 and c5.
    vt[0] = '{1'b1, 1'b1, 1'b1, 64'h100, 1'b0, 64'h0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 64'h104, 1'b0, 64'h0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 64'h0,   1'b1, 64'h100};
    vt[3] = '{1'b1, 1'b1, 1'b1, 64'h108, 1'b1, 64'h104};
    vt[4] = '{1'b1, 1'b1, 1'b1, 64'h10C, 1'b0, 64'h0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 64'h0,   1'b1, 64'h108};
    vt[6] = '{1'b1, 1'b1, 1'b1, 64'h110, 1'b1, 64'h10C};

    // Sequential fetch from RESET_PC with 1-cycle memory.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.dec_ready      = vt[i].dec_rdy;
      bus.imem_req_ready = vt[i].req_rdy;
      @(negedge clk);
      check($sformatf("t1_req_valid[%0d]", i), 64'(bus.imem_req_valid), 64'(vt[i].exp_rv));
      if (vt[i].exp_rv) check($sformatf("t1_req_addr[%0d]", i), bus.imem_req_addr, vt[i].exp_addr);
      check($sformatf("t1_dec_valid[%0d]", i), 64'(bus.dec_valid), 64'(vt[i].exp_dv));
      if (vt[i].exp_dv) check($sformatf("t1_dec_pc[%0d]", i), bus.dec_pc, vt[i].exp_pc);
      finish_cycle();
    end
    check("t1_acc0", acc_log[0], 64'h100);
    check("t1_acc2", acc_log[2], 64'h108);

    // Decode back-pressure: fetch stops at two buffered words, resumes at 0x108.
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b0;
    repeat (6) tick();
    check("t2_req_valid_held", 64'(bus.imem_req_valid), 64'd0);
    check("t2_accepts", 64'(acc_log.size()), 64'd2);
    check("t2_dec_valid", 64'(bus.dec_valid), 64'd1);
    check("t2_head_pc", bus.dec_pc, 64'h100);
    bus.dec_ready = 1'b1;
    repeat (8) tick();
    check("t2_resume_addr", acc_log[2], 64'h108);
    check("t2_pop_count_ok", 64'(pop_log.size() >= 3), 64'd1);
    check("t2_pop2", pop_log[2], 64'h108);
    check("t2_no_dup_104", 64'(count_pc(64'h104)), 64'd1);

    // Memory back-pressure: request held stable for 5 cycles.
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t3_valid[%0d]", k), 64'(bus.imem_req_valid), 64'd1);
      check($sformatf("t3_addr[%0d]", k), bus.imem_req_addr, 64'h104);
      finish_cycle();
    end
    bus.imem_req_ready = 1'b1;
    repeat (6) tick();
    check("t3_acc1", acc_log[1], 64'h104);
    check("t3_pop1", pop_log[1], 64'h104);

    // Redirect with two requests in flight (3-cycle memory).
    do_reset();
    mem_lat            = 3;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    repeat (2) tick();
    check("t4_outstanding", 64'(mem_q.size()), 64'd2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h400;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (12) tick();
    check("t4_next_req", acc_log[2], 64'h400);
    check("t4_first_pop", pop_log[0], 64'h400);
    check("t4_stale_dropped", 64'(count_pc(64'h100) + count_pc(64'h104)), 64'd0);

    // Redirect coinciding with a decode pop, misaligned target.
    do_reset();
    mem_lat            = 1;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    repeat (2) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h403;
    @(negedge clk);
    check("t5_pop_same_cycle", bus.dec_pc, 64'h100);
    finish_cycle();
    bus.redirect_valid = 1'b0;
    repeat (8) tick();
    check("t5_once_100", 64'(count_pc(64'h100)), 64'd1);
    check("t5_flushed_104", 64'(count_pc(64'h104)), 64'd0);
    check("t5_next_req", acc_log[2], 64'h400);
    check("t5_next_pop", pop_log[1], 64'h400);

    // Unconditional branch word at 0x200.
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h200;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (14) tick();
    idx = -1;
    foreach (pop_log[k]) if ((pop_log[k] == 64'h200) && (idx < 0)) idx = k;
    check("t6_b_delivered", 64'(idx >= 0), 64'd1);
    nxt = ((idx >= 0) && (idx + 1 < pop_log.size())) ? pop_log[idx+1] : 64'hDEAD;
`ifdef BRANCH_PREDECODE_EN
    check("t6_next_pc", nxt, 64'h210);
    check("t6_skip_204", 64'(count_pc(64'h204)), 64'd0);
`else
    check("t6_next_pc", nxt, 64'h204);
    check("t6_seq_204", 64'(count_pc(64'h204)), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
